// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: reads four bytes from the byte-wide instruction memory,
// assembles them big-endian and offers the word to decode over valid/ready.
module instr_fetch_unit #(
   parameter int                    ADDR_WIDTH = 8,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic                  mem_rd_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [7:0]            mem_rdata,
   output logic [31:0]           instr,
   output logic [ADDR_WIDTH-1:0] instr_pc,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  fetch_error
);

   typedef enum logic [1:0] {FETCH, DRAIN, HOLD, ERROR} state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] pc;
   logic [1:0]            byte_cnt;
   logic [1:0]            req_idx;
   logic                  cap_en;
   logic [1:0]            cap_idx;
   logic                  bad_redirect;
   logic                  restart;
   logic [ADDR_WIDTH-1:0] restart_pc;

   // A restart (accepted word or aligned redirect) issues byte 0 of the new PC at once.
   assign bad_redirect = (state != ERROR) && redirect_valid && (redirect_pc[1:0] != 2'b00);
   assign restart      = (state != ERROR) && (redirect_valid || ((state == HOLD) && instr_ready));

   always_comb begin
      restart_pc = pc + ADDR_WIDTH'(4);
      if (redirect_valid) begin
         restart_pc = redirect_pc;
      end
   end

   // cap_en/cap_idx trail the request by one cycle so each byte lands when memory returns it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= FETCH;
         pc          <= RESET_PC;
         byte_cnt    <= '0;
         req_idx     <= '0;
         cap_en      <= 1'b0;
         cap_idx     <= '0;
         mem_rd_en   <= 1'b0;
         mem_addr    <= '0;
         instr       <= '0;
         instr_pc    <= RESET_PC;
         instr_valid <= 1'b0;
         fetch_error <= 1'b0;
      end else begin
         mem_rd_en <= 1'b0;
         cap_en    <= mem_rd_en;
         cap_idx   <= req_idx;
         if (bad_redirect) begin
            fetch_error <= 1'b1;
            instr_valid <= 1'b0;
            cap_en      <= 1'b0;
            state       <= ERROR;
         end else if (restart) begin
            pc          <= restart_pc;
            instr_valid <= 1'b0;
            cap_en      <= 1'b0;
            mem_rd_en   <= 1'b1;
            mem_addr    <= restart_pc;
            req_idx     <= 2'd0;
            byte_cnt    <= 2'd1;
            state       <= FETCH;
         end else begin
            if (cap_en) begin
               case (cap_idx)
                  2'd0:    instr[31:24] <= mem_rdata;
                  2'd1:    instr[23:16] <= mem_rdata;
                  2'd2:    instr[15:8]  <= mem_rdata;
                  default: instr[7:0]   <= mem_rdata;
               endcase
            end
            case (state)
               FETCH: begin
                  mem_rd_en <= 1'b1;
                  mem_addr  <= pc + ADDR_WIDTH'(byte_cnt);
                  req_idx   <= byte_cnt;
                  byte_cnt  <= byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3) begin
                     state <= DRAIN;
                  end
               end
               DRAIN: begin
                  if (cap_en && (cap_idx == 2'd3)) begin
                     instr_valid <= 1'b1;
                     instr_pc    <= pc;
                     state       <= HOLD;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule
